clock_div_multi: RTL and testbench
==================================

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter W, default 16, width of ratio and high-time fields.
REQ-003 Parameter RST_RATIO, default 2, per-channel ratio after reset.
REQ-004 Parameter RST_HIGH, default 1, per-channel high-time after reset.
REQ-005 clk_in  input  1  source clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  NCH  per-channel run enable, level sensitive.
REQ-008 cfg_valid  input  1  configuration write request.
REQ-009 cfg_ready  output  1  configuration write accepted when high with cfg_valid.
REQ-010 cfg_ch  input  max(1,clog2(NCH))  target channel of the write.
REQ-011 cfg_ratio  input  W  new period in clk_in cycles.
REQ-012 cfg_high  input  W  new high-time in clk_in cycles.
REQ-013 clk_out  output  NCH  divided clocks, registered.
REQ-014 tick  output  NCH  one-cycle pulse, coincident with each clk_out period start.
REQ-015 busy  output  NCH  channel holds a pending, not-yet-applied configuration.

Function
REQ-016 Each channel SHALL have states IDLE and RUN, an active ratio/high pair, a shadow ratio/high pair and a W-bit counter cnt.
REQ-017 IDLE: cnt=0, clk_out=0, tick=0; en sampled 1 with active ratio>=2 SHALL enter RUN.
REQ-018 The first RUN cycle SHALL have cnt=0, tick=1, clk_out=(high>0); i.e. one cycle latency from en to first edge.
REQ-019 In RUN cnt SHALL count 0..ratio-1 and wrap to 0; period is exactly ratio clk_in cycles.
REQ-020 clk_out SHALL be 1 while cnt<high, else 0; high=0 gives constant 0, high>=ratio constant 1.
REQ-021 tick SHALL be 1 exactly in cycles where RUN and cnt=0.
REQ-022 Active ratio<2 SHALL force IDLE regardless of en (channel halted, clk_out=0, tick=0).
REQ-023 en sampled 0 in RUN SHALL return to IDLE next cycle (immediate stop, may truncate a high phase).
REQ-024 A write SHALL be accepted on cycle where cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal NOT busy[cfg_ch] (combinational).
REQ-025 An accepted write SHALL load the shadow pair and set busy for that channel.
REQ-026 A pending shadow SHALL be applied on the wrap cycle (cnt=ratio-1 to 0), so the next period uses new values; busy clears in that same edge.
REQ-027 A pending shadow in IDLE SHALL be applied on the next edge.
REQ-028 A write with cfg_ch>=NCH SHALL be accepted (cfg_ready=1) and discarded.
REQ-029 Write arriving on the same edge as the wrap for that channel SHALL NOT apply in that wrap; it applies at the following wrap.
REQ-030 Channels SHALL be fully independent; counters, comparisons and arithmetic W bits unsigned, no overflow at ratio=2^W-1.

Reset
REQ-031 On reset low all channels SHALL go IDLE: cnt=0, clk_out=0, tick=0, busy=0, active ratio=RST_RATIO, active high=RST_HIGH, shadow=same.
REQ-032 Reset asserted mid-period SHALL clear outputs immediately (asynchronous); release SHALL resume per REQ-017 on first edge with en=1.

Structure
REQ-033 A shared package clock_div_pkg SHALL hold channel state enum (IDLE, RUN) and default constants RST_RATIO/RST_HIGH.
REQ-034 One sub-module clock_div_chan SHALL implement a single channel (state, counter, active/shadow regs); top instantiates NCH copies and decodes cfg_ch.

Verification
REQ-035 Reset release, en[0]=1, defaults -> clk_out[0] toggles 1,0 every cycle, tick[0] every 2 cycles, first tick one cycle after en.
REQ-036 Write ch1 ratio=5 high=2 while idle, en[1]=1 -> clk_out[1] pattern 1,1,0,0,0 repeating, tick every 5 cycles, busy[1] clears one cycle after write.
REQ-037 Ch2 running ratio=8 high=4, write ratio=3 high=1 at cnt=2 -> current 8-cycle period completes unchanged, then 1,0,0 periods; second write while busy sees cfg_ready=0.
REQ-038 Write high=0 then high=9 with ratio=6 -> clk_out constant 0 then constant 1, tick still every 6 cycles; ratio=1 -> channel stays IDLE, clk_out=0.
REQ-039 Reset asserted at cnt=3 of ratio=7 -> clk_out, tick, busy go 0 without clock edge, config returns to 2/1.
REQ-040 cfg_ch=NCH write -> cfg_ready=1, no channel config or busy changes.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding, reset defaults and a helper for the channel-select width.
package clock_div_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_t;

    // Ratio/high-time loaded into every channel while reset is low.
    localparam int DEFAULT_RST_RATIO = 2;
    localparam int DEFAULT_RST_HIGH  = 1;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int chan_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: IDLE/RUN state, period counter, active and shadow
// ratio/high-time registers. Outputs are registered from next-state values.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int W         = 16,
    parameter int RST_RATIO = DEFAULT_RST_RATIO,
    parameter int RST_HIGH  = DEFAULT_RST_HIGH
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_ratio,
    input  logic [W-1:0] wr_high,
    output logic         clk_out,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] RATIO_INIT = W'(RST_RATIO);
    localparam logic [W-1:0] HIGH_INIT  = W'(RST_HIGH);
    localparam logic [W-1:0] ONE        = W'(1);
    localparam logic [W-1:0] TWO        = W'(2);

    chan_state_t  state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] sh_ratio_q, sh_ratio_d;
    logic [W-1:0] sh_high_q, sh_high_d;
    logic         busy_q, busy_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         at_wrap;
    logic         apply;
    logic         run_ok;

    // Next-state: shadow hand-over at period end (or at once when idle),
    // then run/stop decision against the ratio that will be active.
    always_comb begin
        at_wrap = (state_q == CH_RUN) && (cnt_q >= ratio_q - ONE);
        apply   = busy_q && ((state_q == CH_IDLE) || at_wrap);

        ratio_d = apply ? sh_ratio_q : ratio_q;
        high_d  = apply ? sh_high_q  : high_q;
        run_ok  = en && (ratio_d >= TWO);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CH_IDLE: begin
                cnt_d = '0;
                if (run_ok) begin
                    state_d = CH_RUN;
                end
            end
            CH_RUN: begin
                if (!run_ok) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A write can only arrive while nothing is pending, so it never
        // races with apply; it is picked up at the next qualifying edge.
        sh_ratio_d = wr ? wr_ratio : sh_ratio_q;
        sh_high_d  = wr ? wr_high  : sh_high_q;
        busy_d     = wr ? 1'b1 : (busy_q && !apply);

        tick_d    = (state_d == CH_RUN) && (cnt_d == '0);
        clk_out_d = (state_d == CH_RUN) && (cnt_d < high_d);
    end

    // State registers with asynchronous active-low clear to reset defaults.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= CH_IDLE;
            cnt_q      <= '0;
            ratio_q    <= RATIO_INIT;
            high_q     <= HIGH_INIT;
            sh_ratio_q <= RATIO_INIT;
            sh_high_q  <= HIGH_INIT;
            busy_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            high_q     <= high_d;
            sh_ratio_q <= sh_ratio_d;
            sh_high_q  <= sh_high_d;
            busy_q     <= busy_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;

endmodule

// File: rtl/clock_div_multi.sv
// NCH independent programmable clock dividers sharing one configuration
// port. A write to a channel with a pending update is held off; writes to
// non-existent channels are accepted and dropped.
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int W         = 16,
    parameter int RST_RATIO = DEFAULT_RST_RATIO,
    parameter int RST_HIGH  = DEFAULT_RST_HIGH
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic [NCH-1:0]                   en,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [chan_sel_width(NCH)-1:0]   cfg_ch,
    input  logic [W-1:0]                     cfg_ratio,
    input  logic [W-1:0]                     cfg_high,
    output logic [NCH-1:0]                   clk_out,
    output logic [NCH-1:0]                   tick,
    output logic [NCH-1:0]                   busy
);

    localparam int CHW = chan_sel_width(NCH);

    logic [NCH-1:0] sel;
    logic [NCH-1:0] wr;

    // Ready unless the addressed channel already holds a pending update;
    // an out-of-range cfg_ch selects nothing and is always ready.
    assign cfg_ready = ~|(sel & busy);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign sel[gi] = (cfg_ch == CHW'(gi));
            assign wr[gi]  = cfg_valid & cfg_ready & sel[gi];

            clock_div_chan #(
                .W         (W),
                .RST_RATIO (RST_RATIO),
                .RST_HIGH  (RST_HIGH)
            ) u_chan (
                .clk_in   (clk_in),
                .reset    (reset),
                .en       (en[gi]),
                .wr       (wr[gi]),
                .wr_ratio (cfg_ratio),
                .wr_high  (cfg_high),
                .clk_out  (clk_out[gi]),
                .tick     (tick[gi]),
                .busy     (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// Bench for clock_div_multi: a directed table, hand-written corner
// sequences and a randomized phase, all cross-checked each cycle against a
// period-position reference model.
module tb_clock_div_multi;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_ratio;
    logic [W-1:0]   cfg_high;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    int checks   = 0;
    int failures = 0;

    clock_div_multi #(
        .NCH       (NCH),
        .W         (W),
        .RST_RATIO (2),
        .RST_HIGH  (1)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_ratio (cfg_ratio),
        .cfg_high  (cfg_high),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: each channel knows how far into its period it is.
    int m_ratio [NCH];
    int m_high  [NCH];
    int m_sratio[NCH];
    int m_shigh [NCH];
    bit m_pend  [NCH];
    bit m_run   [NCH];
    int m_pos   [NCH];

    typedef struct {
        logic [2:0] en;
        logic       v;
        logic [1:0] ch;
        logic [7:0] r;
        logic [7:0] h;
        logic       rdy;
        logic [2:0] clk;
        logic [2:0] tk;
        logic [2:0] bsy;
    } vec_t;

    vec_t tbl[15];
    int exp37[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    int exp39[3]  = '{1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ratio[c] = 2; m_high[c] = 1;
            m_sratio[c] = 2; m_shigh[c] = 1;
            m_pend[c] = 0; m_run[c] = 0; m_pos[c] = 0;
        end
    endfunction

    function automatic bit m_ready(input int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic void model_advance(input logic [NCH-1:0] e, input bit v, input int ch,
                                          input int r, input int h);
        bit acc;
        bit period_end;
        acc = v && m_ready(ch);
        for (int c = 0; c < NCH; c++) begin
            period_end = m_run[c] && (m_pos[c] + 1 >= m_ratio[c]);
            if (m_pend[c] && (!m_run[c] || period_end)) begin
                m_ratio[c] = m_sratio[c];
                m_high[c]  = m_shigh[c];
                m_pend[c]  = 0;
            end
            if (m_run[c]) begin
                if (!e[c] || m_ratio[c] < 2) begin
                    m_run[c] = 0; m_pos[c] = 0;
                end else begin
                    m_pos[c] = period_end ? 0 : m_pos[c] + 1;
                end
            end else if (e[c] && m_ratio[c] >= 2) begin
                m_run[c] = 1; m_pos[c] = 0;
            end
            if (acc && ch == c) begin
                m_sratio[c] = r; m_shigh[c] = h; m_pend[c] = 1;
            end
        end
    endfunction

    function automatic logic [NCH-1:0] m_clk();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_run[c] && (m_pos[c] < m_high[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_tick();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_run[c] && (m_pos[c] == 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    // One clock cycle: check ready, clock the DUT and the model, compare.
    task automatic step();
        logic [NCH-1:0] en_s;
        logic           v_s;
        int             ch_s, r_s, h_s;
        #1;
        en_s = en; v_s = cfg_valid; ch_s = int'(cfg_ch);
        r_s = int'(cfg_ratio); h_s = int'(cfg_high);
        chk("cfg_ready", cfg_ready, m_ready(ch_s));
        @(posedge clk_in);
        #1;
        if (!reset) model_reset();
        else model_advance(en_s, v_s, ch_s, r_s, h_s);
        chk("clk_out", clk_out, m_clk());
        chk("tick", tick, m_tick());
        chk("busy", busy, m_busy());
        $display("cyc t=%0t en=%b v=%b ch=%0d r=%0d h=%0d -> clk_out=%b tick=%b busy=%b",
                 $time, en_s, v_s, ch_s, r_s, h_s, clk_out, tick, busy);
    endtask

    task automatic set_wr(input int ch, input int r, input int h);
        cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_ratio = W'(r); cfg_high = W'(h);
    endtask

    task automatic clr_wr();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_clear(input int c, input int budget);
        int n;
        n = 0;
        while (busy[c] && n < budget) begin
            step();
            n++;
        end
        chk("busy_clear_timeout", 32'(busy[c]), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] e, input logic v, input logic [1:0] ch,
                                input logic [7:0] r, input logic [7:0] h, input logic rdy,
                                input logic [2:0] ck, input logic [2:0] tk, input logic [2:0] b);
        vec_t t;
        t.en = e; t.v = v; t.ch = ch; t.r = r; t.h = h;
        t.rdy = rdy; t.clk = ck; t.tk = tk; t.bsy = b;
        return t;
    endfunction

    initial begin
        int tcnt;

        // Default run on ch0, then program ch1 to 5/2 while idle and run it.
        tbl[0]  = mk(3'b001, 0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000);
        tbl[1]  = mk(3'b001, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[2]  = mk(3'b001, 0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000);
        tbl[3]  = mk(3'b001, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[4]  = mk(3'b000, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[5]  = mk(3'b000, 1, 1, 5, 2, 1, 3'b000, 3'b000, 3'b010);
        tbl[6]  = mk(3'b000, 0, 1, 5, 2, 0, 3'b000, 3'b000, 3'b000);
        tbl[7]  = mk(3'b010, 0, 1, 0, 0, 1, 3'b010, 3'b010, 3'b000);
        tbl[8]  = mk(3'b010, 0, 1, 0, 0, 1, 3'b010, 3'b000, 3'b000);
        tbl[9]  = mk(3'b010, 0, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[10] = mk(3'b010, 0, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[11] = mk(3'b010, 0, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[12] = mk(3'b010, 0, 1, 0, 0, 1, 3'b010, 3'b010, 3'b000);
        tbl[13] = mk(3'b010, 0, 1, 0, 0, 1, 3'b010, 3'b000, 3'b000);
        tbl[14] = mk(3'b000, 0, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000);

        reset = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_ratio = '0; cfg_high = '0;
        model_reset();
        step();
        step();
        chk("rst_clk_out", clk_out, 3'b000);
        chk("rst_tick", tick, 3'b000);
        chk("rst_busy", busy, 3'b000);
        #2 reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en; cfg_valid = tbl[i].v; cfg_ch = tbl[i].ch;
            cfg_ratio = tbl[i].r; cfg_high = tbl[i].h;
            #1;
            chk("tbl_ready", cfg_ready, tbl[i].rdy);
            step();
            chk("tbl_clk_out", clk_out, tbl[i].clk);
            chk("tbl_tick", tick, tbl[i].tk);
            chk("tbl_busy", busy, tbl[i].bsy);
        end
        clr_wr();

        // Update mid-period: the 8-cycle period finishes before 3/1 takes over.
        set_wr(2, 8, 4); step(); clr_wr(); step();
        en[2] = 1'b1; step(); step(); step();
        set_wr(2, 3, 1); step();
        chk("seq37", 32'(clk_out[2]), 32'(exp37[0]));
        set_wr(2, 4, 2); #1;
        chk("ready_while_busy", 32'(cfg_ready), 32'd0);
        for (int k = 1; k < 11; k++) begin
            step();
            clr_wr();
            chk("seq37", 32'(clk_out[2]), 32'(exp37[k]));
        end

        // high=0 gives constant low, high>=ratio constant high, ratio=1 halts.
        set_wr(2, 6, 0); step(); clr_wr(); wait_clear(2, 20);
        tcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            chk("high0_clk", 32'(clk_out[2]), 32'd0);
            tcnt += int'(tick[2]);
        end
        chk("high0_ticks", tcnt, 2);
        set_wr(2, 6, 9); step(); clr_wr(); wait_clear(2, 20);
        tcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            chk("high9_clk", 32'(clk_out[2]), 32'd1);
            tcnt += int'(tick[2]);
        end
        chk("high9_ticks", tcnt, 2);
        set_wr(2, 1, 0); step(); clr_wr(); wait_clear(2, 20);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ratio1_halt", {31'd0, clk_out[2] | tick[2]}, 32'd0);
        end

        // Asynchronous reset in the middle of a 7-cycle period.
        en[0] = 1'b0;
        set_wr(0, 7, 5); step(); clr_wr(); step();
        en[0] = 1'b1; step(); step(); step();
        set_wr(0, 4, 2); step(); clr_wr();
        chk("pre_rst_clk", 32'(clk_out[0]), 32'd1);
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_clk_out", clk_out, 3'b000);
        chk("async_tick", tick, 3'b000);
        chk("async_busy", busy, 3'b000);
        model_reset();
        en = 3'b001;
        step();
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_clk", 32'(clk_out[0]), 32'(exp39[k]));
            chk("post_rst_tick", 32'(tick[0]), 32'(exp39[k]));
        end

        // Write to a channel that does not exist.
        set_wr(NCH, 9, 3); #1;
        chk("oob_ready", 32'(cfg_ready), 32'd1);
        step(); clr_wr();
        chk("oob_busy", busy, 3'b000);
        step(); step(); step();

        // Long period near the top of the ratio range.
        en = '0; step();
        set_wr(1, 255, 254); step(); clr_wr(); step();
        en[1] = 1'b1;
        for (int k = 0; k < 260; k++) step();

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_ratio = ($urandom_range(0, 40) == 0) ? 8'd255 : W'($urandom_range(0, 12));
            cfg_high  = W'($urandom_range(0, 13));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
